// File: rtl/bsg_hash_bank_pkg.sv
// Shared types and helpers for the banked-memory hash blocks.
package bsg_hash_bank_pkg;

  localparam int default_index_width_lp = 16;
  localparam int default_data_width_lp  = 32;

  // Bank response at the default widths; parameterised blocks slice ports directly.
  typedef struct packed {
    logic [default_index_width_lp-1:0] index;
    logic [default_data_width_lp-1:0]  data;
  } bank_resp_s;

  function automatic int lg_banks(input int banks);
    return (banks > 1) ? $clog2(banks) : 0;
  endfunction

  // A bank id port keeps at least one bit even when there is a single bank.
  function automatic int bank_id_width(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

endpackage

// File: rtl/bsg_hash_bank_reverse.sv
// Reverse bank hash: rebuilds a global address from a bank id and its bank-local index.
module bsg_hash_bank_reverse
  import bsg_hash_bank_pkg::*;
#(
  parameter int banks_p = 4,
  parameter int width_p = 16,
  localparam int lg_banks_lp = lg_banks(banks_p),
  localparam int bank_w_lp   = bank_id_width(banks_p)
) (
  input  logic [bank_w_lp-1:0]           bank_i,
  input  logic [width_p-1:0]             index_i,
  output logic [width_p+lg_banks_lp-1:0] addr_o
);

  if (lg_banks_lp == 0) begin : g_single
    // With one bank there is no id field; the index is already the address.
    logic unused_bank;
    assign unused_bank = ^bank_i;
    assign addr_o      = index_i;
  end else begin : g_multi
    assign addr_o = {index_i, bank_i};
  end

endmodule

// File: rtl/bsg_hash_bank_reverse_arb.sv
// Round-robin return-path arbiter: grants one bank per cycle into a registered output
// entry carrying the reconstructed global address.
module bsg_hash_bank_reverse_arb
  import bsg_hash_bank_pkg::*;
#(
  parameter int banks_p       = 4,
  parameter int index_width_p = 16,
  parameter int data_width_p  = 32,
  localparam int lg_banks_lp  = lg_banks(banks_p),
  localparam int bank_w_lp    = bank_id_width(banks_p)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n_i,
  input  logic [banks_p-1:0]                   v_i,
  input  logic [banks_p*index_width_p-1:0]     index_i,
  input  logic [banks_p*data_width_p-1:0]      data_i,
  output logic [banks_p-1:0]                   ready_o,
  output logic                                 v_o,
  output logic [index_width_p+lg_banks_lp-1:0] addr_o,
  output logic [data_width_p-1:0]              data_o,
  output logic [bank_w_lp-1:0]                 bank_o,
  input  logic                                 ready_i
);

  logic                                 v_q, v_d;
  logic [index_width_p+lg_banks_lp-1:0] addr_q, addr_d;
  logic [data_width_p-1:0]              data_q, data_d;
  logic [bank_w_lp-1:0]                 bank_q, bank_d;
  logic [bank_w_lp-1:0]                 last_q, last_d;

  logic [index_width_p-1:0]             index_arr [banks_p];
  logic [data_width_p-1:0]              data_arr  [banks_p];
  logic [index_width_p+lg_banks_lp-1:0] rev_addr;
  logic [bank_w_lp-1:0]                 winner;
  logic                                 found;
  logic                                 load;
  logic                                 grant_ok;

  for (genvar gi = 0; gi < banks_p; gi++) begin : g_unpack
    assign index_arr[gi] = index_i[gi*index_width_p +: index_width_p];
    assign data_arr[gi]  = data_i[gi*data_width_p +: data_width_p];
  end

  if (banks_p == 1) begin : g_one
    logic unused_last;
    assign unused_last = ^last_q;
    assign found       = v_i[0];
    assign winner      = '0;
  end else begin : g_rr
    logic [bank_w_lp-1:0] cand;
    // Scan offsets from farthest to nearest so the bank right after last_q wins.
    always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = banks_p; k >= 1; k--) begin
        cand = last_q + bank_w_lp'(k);
        if (v_i[cand]) begin
          found  = 1'b1;
          winner = cand;
        end
      end
    end
  end

  assign load     = ~v_q | ready_i;
  assign grant_ok = reset_n_i & load & found;

  for (genvar gi = 0; gi < banks_p; gi++) begin : g_ready
    assign ready_o[gi] = grant_ok & (winner == bank_w_lp'(gi));
  end

  bsg_hash_bank_reverse #(
    .banks_p (banks_p),
    .width_p (index_width_p)
  ) u_reverse (
    .bank_i  (winner),
    .index_i (index_arr[winner]),
    .addr_o  (rev_addr)
  );

  always_comb begin
    v_d    = v_q;
    addr_d = addr_q;
    data_d = data_q;
    bank_d = bank_q;
    last_d = last_q;
    if (load) begin
      v_d = found;
      if (found) begin
        addr_d = rev_addr;
        data_d = data_arr[winner];
        bank_d = winner;
        last_d = winner;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      v_q    <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      bank_q <= '0;
      last_q <= bank_w_lp'(banks_p - 1);
    end else begin
      v_q    <= v_d;
      addr_q <= addr_d;
      data_q <= data_d;
      bank_q <= bank_d;
      last_q <= last_d;
    end
  end

  assign v_o    = v_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign bank_o = bank_q;

endmodule

// File: tb/tb_bsg_hash_bank_reverse_arb.sv
// Scoreboard bench: per-bank sources, a round-robin reference model and an output monitor.
module tb_bsg_hash_bank_reverse_arb;
  import bsg_hash_bank_pkg::*;

  typedef struct packed {
    logic [17:0] addr;
    logic [31:0] data;
    logic [1:0]  bank;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   v_i = '0;
  logic [63:0]  index_i = '0;
  logic [127:0] data_i = '0;
  logic [3:0]   ready_o;
  logic         v_o;
  logic [17:0]  addr_o;
  logic [31:0]  data_o;
  logic [1:0]   bank_o;
  logic         ready_i = 1'b1;

  logic [0:0]   v1_i = 1'b0;
  logic [15:0]  index1_i = '0;
  logic [31:0]  data1_i = '0;
  logic [0:0]   ready1_o;
  logic         v1_o;
  logic [15:0]  addr1_o;
  logic [31:0]  data1_o;
  logic [0:0]   bank1_o;
  logic         ready1_i = 1'b1;

  bsg_hash_bank_reverse_arb #(.banks_p(4), .index_width_p(16), .data_width_p(32)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v_i), .index_i(index_i), .data_i(data_i),
    .ready_o(ready_o), .v_o(v_o), .addr_o(addr_o), .data_o(data_o), .bank_o(bank_o),
    .ready_i(ready_i)
  );

  bsg_hash_bank_reverse_arb #(.banks_p(1), .index_width_p(16), .data_width_p(32)) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v1_i), .index_i(index1_i), .data_i(data1_i),
    .ready_o(ready1_o), .v_o(v1_o), .addr_o(addr1_o), .data_o(data1_o), .bank_o(bank1_o),
    .ready_i(ready1_i)
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;

  bank_resp_s src_q [4][$];
  logic [3:0] held = '0;
  int         raise_pct = 100;
  exp_t       exp_q [$];
  int         dut_grants [$];
  int         grant_cycle [$];
  int         cyc = 0;
  int         pushed = 0, retired = 0, dropped = 0, dut_xfers = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h at t=%0t", name, act, req, $time);
  endtask

  task automatic push_src(input int b, input logic [15:0] idx, input logic [31:0] dat);
    bank_resp_s r;
    r.index = idx;
    r.data  = dat;
    src_q[b].push_back(r);
    pushed++;
  endtask

  // Driver: raise a bank's valid when it has work, hold it until the model sees it taken.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int b = 0; b < 4; b++) begin
        if (!held[b] && src_q[b].size() > 0 && $urandom_range(0, 99) < raise_pct) held[b] = 1'b1;
        v_i[b] = held[b];
        if (held[b]) begin
          index_i[b*16 +: 16] = src_q[b][0].index;
          data_i[b*32 +: 32]  = src_q[b][0].data;
        end else begin
          index_i[b*16 +: 16] = 16'($urandom);
          data_i[b*32 +: 32]  = $urandom;
        end
      end
    end
  end

  // Reference model: round robin over valid banks, starting after the last winner.
  initial begin
    bit   m_vo;
    int   m_last;
    bit   load;
    int   win;
    logic [3:0] expr;
    exp_t e;
    m_vo = 0;
    m_last = 3;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        chk("ready_in_reset", 64'(ready_o), 64'd0);
        m_vo = 0;
        m_last = 3;
        dropped += exp_q.size();
        exp_q.delete();
      end else begin
        load = !m_vo || ready_i;
        win = -1;
        if (load) begin
          for (int k = 1; k <= 4; k++) begin
            if (win < 0 && v_i[(m_last + k) % 4]) win = (m_last + k) % 4;
          end
        end
        expr = (win >= 0) ? (4'b0001 << win) : 4'b0000;
        chk("ready_o", 64'(ready_o), 64'(expr));
        for (int b = 0; b < 4; b++) begin
          if (ready_o[b] && v_i[b]) begin
            dut_grants.push_back(b);
            grant_cycle.push_back(cyc);
            dut_xfers++;
          end
        end
        if (load) begin
          if (win >= 0) begin
            e.addr = 18'(int'(src_q[win][0].index) * 4 + win);
            e.data = src_q[win][0].data;
            e.bank = 2'(win);
            exp_q.push_back(e);
            void'(src_q[win].pop_front());
            held[win] = 1'b0;
            m_last = win;
          end
          m_vo = (win >= 0);
        end
      end
    end
  end

  // Monitor: compare the presented entry with the scoreboard head every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("v_o", 64'(v_o), 64'(exp_q.size() != 0));
        if (v_o && exp_q.size() > 0) begin
          e = exp_q[0];
          chk("addr_o", 64'(addr_o), 64'(e.addr));
          chk("data_o", 64'(data_o), 64'(e.data));
          chk("bank_o", 64'(bank_o), 64'(e.bank));
          if (ready_i) begin
            void'(exp_q.pop_front());
            retired++;
          end
        end
      end
    end
  end

  task automatic drain(input string nm);
    bit done;
    bit empty;
    done = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      empty = 1;
      for (int b = 0; b < 4; b++) if (src_q[b].size() != 0) empty = 0;
      if (empty && exp_q.size() == 0 && !v_o) begin
        done = 1;
        break;
      end
    end
    chk(nm, 64'(done), 64'd1);
  endtask

  task automatic wait_vo(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (v_o) begin
        seen = 1;
        break;
      end
    end
    chk(nm, 64'(seen), 64'd1);
  endtask

  initial begin
    int n0;
    logic [17:0] s_addr;
    logic [31:0] s_data;
    logic [1:0]  s_bank;

    v1_i = 1'b1;
    index1_i = 16'hABCD;
    data1_i = 32'h5555AAAA;
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 8; j++) push_src(b, 16'($urandom), $urandom);

    // Reset held for 3 edges with every bank valid.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("deg_v_o_after_reset", 64'(v1_o), 64'd0);
    @(negedge clk);
    chk("deg_v_o", 64'(v1_o), 64'd1);
    chk("deg_addr_o", 64'(addr1_o), 64'hABCD);
    chk("deg_bank_o", 64'(bank1_o), 64'd0);
    chk("deg_data_o", 64'(data1_o), 64'h5555AAAA);
    drain("drain_rr");
    if (dut_grants.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("rr_order", 64'(dut_grants[i]), 64'(i % 4));
        chk("rr_no_bubble", 64'(grant_cycle[i] - grant_cycle[0]), 64'(i));
      end
    end else chk("rr_grant_count", 64'(dut_grants.size()), 64'd8);

    // Single bank with a fixed address pattern.
    @(posedge clk);
    #1 push_src(2, 16'h1234, 32'hDEADBEEF);
    wait_vo("single_wait");
    chk("single_addr", 64'(addr_o), 64'h048D2);
    chk("single_bank", 64'(bank_o), 64'd2);
    chk("single_data", 64'(data_o), 64'hDEADBEEF);
    drain("drain_single");

    // Back-pressure with all banks pending.
    @(posedge clk);
    #1 ready_i = 1'b0;
    for (int b = 0; b < 4; b++)
      for (int j = 0; j < 2; j++) push_src(b, 16'($urandom), $urandom);
    wait_vo("bp_wait");
    s_addr = addr_o;
    s_data = data_o;
    s_bank = bank_o;
    n0 = dut_grants.size();
    repeat (5) begin
      @(negedge clk);
      chk("bp_addr_stable", 64'(addr_o), 64'(s_addr));
      chk("bp_data_stable", 64'(data_o), 64'(s_data));
      chk("bp_ready_zero", 64'(ready_o), 64'd0);
    end
    @(posedge clk);
    #1 ready_i = 1'b1;
    drain("drain_bp");
    if (dut_grants.size() > n0) chk("bp_next_grant", 64'(dut_grants[n0]), 64'((s_bank + 1) % 4));
    else chk("bp_grant_count", 64'(dut_grants.size()), 64'(n0 + 1));

    // Random traffic and back-pressure.
    raise_pct = 60;
    repeat (300) begin
      @(posedge clk);
      #1;
      ready_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) push_src($urandom_range(0, 3), 16'($urandom), $urandom);
    end
    @(posedge clk);
    #1 ready_i = 1'b1;
    raise_pct = 100;
    drain("drain_random");

    // Reset while an entry is stalled at the output.
    @(posedge clk);
    #1 ready_i = 1'b0;
    push_src(1, 16'($urandom), $urandom);
    push_src(3, 16'($urandom), $urandom);
    push_src(3, 16'($urandom), $urandom);
    wait_vo("midrst_wait");
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_v_o", 64'(v_o), 64'd0);
    @(posedge clk);
    #1 ready_i = 1'b1;
    drain("drain_midrst");

    chk("xfer_count", 64'(dut_xfers), 64'(pushed));
    chk("retire_count", 64'(retired + dropped), 64'(pushed));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bsg_hash_bank_reverse_arb.md
# bsg_hash_bank_reverse_arb

Round-robin return-path arbiter for a banked memory. Each of `banks_p` banks returns a response tagged with its bank-local index. The block grants one bank per cycle and reconstructs the original global address through the reverse bank hash. It then presents the address and data on a single registered valid/ready output toward the requester. It sits between the bank return ports and the core-side response network.

## Interface
Parameters:
- `banks_p`, default 4: number of banks. Must be a power of two, ≥1.
- `index_width_p`, default 16: bank-local index width.
- `data_width_p`, default 32: response payload width.
- `lg_banks_lp`: derived, `$clog2(banks_p)`. It is 0 when `banks_p`=1, in which case the bank id field is absent.

Ports:
- `clk_i`, input, 1: the single clock.
- `reset_n_i`, input, 1: reset, synchronous, active-low.
- `v_i`, input, `banks_p`: per-bank response valid.
- `index_i`, input, `banks_p*index_width_p`: per-bank local index. Bank b occupies slice b.
- `data_i`, input, `banks_p*data_width_p`: per-bank payload.
- `ready_o`, output, `banks_p`: per-bank accept. A transfer happens on `v_i[b] & ready_o[b]`.
- `v_o`, output, 1: output entry valid.
- `addr_o`, output, `index_width_p+lg_banks_lp`: reconstructed global address.
- `data_o`, output, `data_width_p`: payload of the output entry.
- `bank_o`, output, `max(1,lg_banks_lp)`: bank id of the output entry.
- `ready_i`, input, 1: downstream accept.

## Operation
- **Output register.** The block has a single-entry output register holding `v_o`, `addr_o`, `data_o` and `bank_o`.
- **Load enable.** `load = ~v_o | ready_i`.
  - When `load`=1, the register captures the granted bank, or clears `v_o` if no bank is granted.
  - When `load`=0, the register holds its contents.
- **Arbitration.**
  - Round-robin over the banks with `v_i` set.
  - Priority starts at `last_r+1` and wraps modulo `banks_p`.
  - Exactly one `ready_o` bit is asserted, for the winner, and only when `load`=1 and some `v_i` bit is set. All other `ready_o` bits are 0.
- **Pointer update.** `last_r` updates to the winner only on an actual transfer.
- **Reverse hash.**
  - `addr_o = {index_i[winner], winner}`, i.e. the bank id in the low bits.
  - For `banks_p`=1, `addr_o = index_i` with no modification.
  - `bank_o` = winner id, or 0 when `banks_p`=1.
- **Upstream contract.** Once a bank raises `v_i[b]`, it holds it, with stable `index_i`/`data_i`, until accepted. The bench checks this; the design does not.
- **Ordering and fairness.** Ordering is preserved per bank. No bank waits more than `banks_p-1` grants while it is continuously valid.
- **Combinational path.** `ready_o` depends combinationally on `ready_i`. This is the intended pipe-register behaviour: full throughput, one transfer per cycle.

## Timing
- **Reset** (`reset_n_i`=0 at a clock edge):
  - `v_o`=0 and `last_r=banks_p-1`, so bank 0 has first priority.
  - `addr_o`, `data_o` and `bank_o` reset to 0.
  - `ready_o`=0 during any cycle in which `reset_n_i`=0.
- **Latency.** One cycle from the input handshake to `v_o`=1 with that entry.
- **Throughput.** One response per cycle while `ready_i`=1.
- **Back-pressure.** With `v_o`=1 and `ready_i`=0, the output is held stable and all `ready_o` bits are 0.
- **Simultaneous drain and fill.** When `v_o`=1, `ready_i`=1 and a bank is valid in the same cycle, the next entry loads with no bubble.
- **Reset mid-operation.** A pending output entry is dropped and the pointer reinitialised. Upstream holds its valid and is re-arbitrated after reset.

## Structure
- **Shared package `bsg_hash_bank_pkg`:** the `lg_banks` helper function and a struct type for a bank response {index, data}. The arbiter and the forward hash block both use them.
- **Sub-module:** instantiate `bsg_hash_bank_reverse` (banks_p, width_p=index_width_p) for address reconstruction.
- **Arbiter:** the round-robin logic stays inline. A separate `bsg_arb_round_robin` is acceptable if present.

## Test plan
- **Reset:** `banks_p`=4. Hold `reset_n_i`=0 for 3 cycles with all `v_i`=1 → `ready_o`=0 and `v_o`=0; the first grant after release goes to bank 0.
- **Single bank:** bank 2 `index_i`=0x1234, `data_i`=0xDEADBEEF, `ready_i`=1 → the next cycle shows `v_o`=1, `addr_o`=0x48D2, `bank_o`=2, `data_o`=0xDEADBEEF.
- **Round robin:** all 4 banks continuously valid, `ready_i`=1 → grant order 0,1,2,3,0,… with one grant per cycle and no bubbles.
- **Back-pressure:** `ready_i`=0 for 5 cycles with `v_o`=1 → outputs stable and `ready_o`=0; on `ready_i`=1, the held entry retires and the next grant goes to `last_r+1`.
- **Degenerate banks:** `banks_p`=1, `index_i`=0xABCD → `addr_o`=0xABCD and `bank_o`=0.
- **Mid-operation reset:** assert reset while `v_o`=1 and `ready_i`=0 → `v_o`=0 the next cycle, and no duplicate or lost handshake is counted by the scoreboard after release.
